// File: rtl/decode_table_arbiter.sv
// Arbitrates the single-port dictionary table between decode reads and config writes.
// Decode has priority; starve_cnt forces a config grant after STARVE_MAX decode grants.
module decode_table_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_W     = 6,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_req,
    input  logic [ADDR_W-1:0] dec_addr,
    output logic              dec_gnt,
    output logic              dec_rvalid,
    output logic [WIDTH-1:0]  dec_rdata,
    input  logic              cfg_req,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [WIDTH-1:0]  cfg_wdata,
    output logic              cfg_gnt,
    output logic              tbl_en,
    output logic              tbl_we,
    output logic [ADDR_W-1:0] tbl_addr,
    output logic [WIDTH-1:0]  tbl_wdata,
    input  logic [WIDTH-1:0]  tbl_rdata,
    output logic              busy
);
    // state | meaning
    // IDLE  | arbitrating; samples dec_req/cfg_req every cycle
    // RD    | read issued, counting down lat_cnt until tbl_rdata is valid
    // WR    | write issued, single cycle before returning to IDLE
    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

    localparam int LAT_W = 3;
    localparam int ST_W  = 4;

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [ST_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic              dec_gnt_q, dec_gnt_d;
    logic              cfg_gnt_q, cfg_gnt_d;
    logic              dec_rvalid_q, dec_rvalid_d;
    logic              tbl_en_q, tbl_en_d;
    logic              tbl_we_q, tbl_we_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] tbl_addr_q, tbl_addr_d;
    logic [WIDTH-1:0]  tbl_wdata_q, tbl_wdata_d;
    logic [WIDTH-1:0]  dec_rdata_q, dec_rdata_d;
    logic              starved;
    logic              cfg_wins;

    assign starved  = (starve_cnt_q == ST_W'(STARVE_MAX));
    assign cfg_wins = cfg_req && (!dec_req || starved);

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        dec_gnt_d    = 1'b0;
        cfg_gnt_d    = 1'b0;
        dec_rvalid_d = 1'b0;
        tbl_en_d     = 1'b0;
        tbl_we_d     = 1'b0;
        tbl_addr_d   = tbl_addr_q;
        tbl_wdata_d  = tbl_wdata_q;
        dec_rdata_d  = dec_rdata_q;
        case (state_q)
            IDLE: begin
                if (cfg_wins) begin
                    cfg_gnt_d    = 1'b1;
                    tbl_en_d     = 1'b1;
                    tbl_we_d     = 1'b1;
                    tbl_addr_d   = cfg_addr;
                    tbl_wdata_d  = cfg_wdata;
                    starve_cnt_d = '0;
                    state_d      = WR;
                end else if (dec_req) begin
                    dec_gnt_d  = 1'b1;
                    tbl_en_d   = 1'b1;
                    tbl_addr_d = dec_addr;
                    lat_cnt_d  = LAT_W'(RD_LAT);
                    state_d    = RD;
                    // Only grants that bypass a waiting writer count toward starvation.
                    if (!cfg_req)
                        starve_cnt_d = '0;
                    else if (!starved)
                        starve_cnt_d = starve_cnt_q + 1'b1;
                end else if (!cfg_req) begin
                    starve_cnt_d = '0;
                end
            end
            RD: begin
                if (lat_cnt_q == '0) begin
                    dec_rvalid_d = 1'b1;
                    dec_rdata_d  = tbl_rdata;
                    state_d      = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            dec_gnt_q    <= 1'b0;
            cfg_gnt_q    <= 1'b0;
            dec_rvalid_q <= 1'b0;
            tbl_en_q     <= 1'b0;
            tbl_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            tbl_addr_q   <= '0;
            tbl_wdata_q  <= '0;
            dec_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            dec_gnt_q    <= dec_gnt_d;
            cfg_gnt_q    <= cfg_gnt_d;
            dec_rvalid_q <= dec_rvalid_d;
            tbl_en_q     <= tbl_en_d;
            tbl_we_q     <= tbl_we_d;
            busy_q       <= busy_d;
            tbl_addr_q   <= tbl_addr_d;
            tbl_wdata_q  <= tbl_wdata_d;
            dec_rdata_q  <= dec_rdata_d;
        end
    end

    assign dec_gnt    = dec_gnt_q;
    assign cfg_gnt    = cfg_gnt_q;
    assign dec_rvalid = dec_rvalid_q;
    assign dec_rdata  = dec_rdata_q;
    assign tbl_en     = tbl_en_q;
    assign tbl_we     = tbl_we_q;
    assign tbl_addr   = tbl_addr_q;
    assign tbl_wdata  = tbl_wdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_decode_table_arbiter.sv
// Bench for decode_table_arbiter: three instances (RD_LAT 1, 3, 4) each driven by random and
// directed requesters and compared every cycle against a transaction-level reference model.
module tb_decode_table_arbiter;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 6;
    localparam int SMAX   = 4;

    int n_tests = 0;
    int n_fail  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lat
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);

        logic              rst_n;
        logic              dec_req, cfg_req;
        logic [ADDR_W-1:0] dec_addr, cfg_addr;
        logic [WIDTH-1:0]  cfg_wdata;
        logic              dec_gnt, dec_rvalid, cfg_gnt, tbl_en, tbl_we, busy;
        logic [WIDTH-1:0]  dec_rdata, tbl_wdata, tbl_rdata;
        logic [ADDR_W-1:0] tbl_addr;
        bit                done = 1'b0;

        decode_table_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .RD_LAT(LAT), .STARVE_MAX(SMAX)) dut (
            .clk(clk), .reset(rst_n),
            .dec_req(dec_req), .dec_addr(dec_addr), .dec_gnt(dec_gnt),
            .dec_rvalid(dec_rvalid), .dec_rdata(dec_rdata),
            .cfg_req(cfg_req), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_gnt(cfg_gnt),
            .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
            .tbl_rdata(tbl_rdata), .busy(busy)
        );

        // Table RAM: contents start at zero, read data emerges LAT cycles after tbl_en.
        logic [WIDTH-1:0] tbl_mem [64] = '{default: '0};
        logic [WIDTH-1:0] pipe [LAT];
        always @(posedge clk) begin
            if (tbl_en && tbl_we) tbl_mem[tbl_addr] <= tbl_wdata;
            pipe[0] <= (tbl_en && !tbl_we) ? tbl_mem[tbl_addr] : $urandom;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign tbl_rdata = pipe[LAT-1];

        // Reference model: edge counter, next edge the arbiter may sample, one outstanding read.
        logic [WIDTH-1:0]  ref_mem [64];
        int                cyc, next_s, starve, rv_at;
        bit                rv_pend;
        logic [WIDTH-1:0]  rv_data, e_rdata, e_twdata;
        logic [ADDR_W-1:0] e_taddr;
        bit                e_dg, e_cg, e_rv, e_busy;
        int                md, mc;
        string             pfx;

        task automatic model_reset();
            cyc = 0; next_s = 0; starve = 0; rv_at = 0; rv_pend = 0;
            e_dg = 0; e_cg = 0; e_rv = 0; e_busy = 0;
            e_rdata = '0; e_twdata = '0; e_taddr = '0; rv_data = '0;
        endtask

        task automatic model_step();
            e_dg = 0; e_cg = 0; e_rv = 0;
            if (rv_pend && cyc == rv_at) begin
                e_rv = 1; e_rdata = rv_data; rv_pend = 0;
            end
            if (cyc >= next_s) begin
                if (cfg_req && (!dec_req || starve == SMAX)) begin
                    e_cg = 1; e_taddr = cfg_addr; e_twdata = cfg_wdata;
                    ref_mem[cfg_addr] = cfg_wdata;
                    starve = 0;
                    next_s = cyc + 2;
                end else if (dec_req) begin
                    e_dg = 1; e_taddr = dec_addr;
                    starve = cfg_req ? ((starve + 1 > SMAX) ? SMAX : starve + 1) : 0;
                    rv_pend = 1; rv_at = cyc + LAT + 1; rv_data = ref_mem[dec_addr];
                    next_s = cyc + LAT + 2;
                end else if (!cfg_req) begin
                    starve = 0;
                end
            end
            e_busy = (cyc + 1 < next_s);
            cyc++;
        endtask

        task automatic check_outs();
            check_eq({pfx, "dec_gnt"},    64'(dec_gnt),    64'(e_dg));
            check_eq({pfx, "cfg_gnt"},    64'(cfg_gnt),    64'(e_cg));
            check_eq({pfx, "dec_rvalid"}, 64'(dec_rvalid), 64'(e_rv));
            check_eq({pfx, "busy"},       64'(busy),       64'(e_busy));
            check_eq({pfx, "tbl_en"},     64'(tbl_en),     64'(e_dg | e_cg));
            check_eq({pfx, "tbl_we"},     64'(tbl_we),     64'(e_cg));
            check_eq({pfx, "tbl_addr"},   64'(tbl_addr),   64'(e_taddr));
            check_eq({pfx, "tbl_wdata"},  64'(tbl_wdata),  64'(e_twdata));
            check_eq({pfx, "dec_rdata"},  64'(dec_rdata),  64'(e_rdata));
        endtask

        // Requesters: mode 0 = finish current request only, 1 = random, 2 = always requesting.
        task automatic drive();
            if (dec_req && !e_dg) begin
                if (md == 1 && $urandom_range(15) == 0) dec_req = 1'b0;
            end else begin
                dec_req  = (md == 2) || (md == 1 && $urandom_range(99) < 32'd50);
                dec_addr = 6'($urandom_range(7));
            end
            if (cfg_req && !e_cg) begin
                if (mc == 1 && $urandom_range(15) == 0) cfg_req = 1'b0;
            end else begin
                cfg_req   = (mc == 2) || (mc == 1 && $urandom_range(99) < 32'd30);
                cfg_addr  = 6'($urandom_range(7));
                cfg_wdata = $urandom;
            end
        endtask

        task automatic step();
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_outs();
            drive();
        endtask

        initial begin
            int t, rv_t, cg_t, dg_t, run;
            bit seen;
            pfx = $sformatf("L%0d ", LAT);
            for (int i = 0; i < 64; i++) ref_mem[i] = '0;
            md = 0; mc = 0;
            rst_n = 1'b0; dec_req = 1'b0; cfg_req = 1'b0;
            dec_addr = '0; cfg_addr = '0; cfg_wdata = '0;
            model_reset();
            repeat (2) @(negedge clk);
            check_outs();
            rst_n = 1'b1;

            // Read of addr 5 after loading 0xDEADBEEF; sample edge to rvalid is LAT+2 cycles.
            cfg_req = 1'b1; cfg_addr = 6'd5; cfg_wdata = 32'hDEADBEEF;
            repeat (4) step();
            dec_req = 1'b1; dec_addr = 6'd5;
            t = 0;
            do begin step(); t++; end while (!dec_rvalid && t < 20);
            check_eq({pfx, "rd_latency"}, 64'(t), 64'(LAT + 2));
            check_eq({pfx, "rd_data5"}, 64'(dec_rdata), 64'(32'hDEADBEEF));

            // Write then read back addr 3.
            cfg_req = 1'b1; cfg_addr = 6'd3; cfg_wdata = 32'h12345678;
            t = 0;
            do begin step(); t++; end while (!cfg_gnt && t < 20);
            check_eq({pfx, "wr_we"}, 64'(tbl_we), 64'(1));
            check_eq({pfx, "wr_wdata"}, 64'(tbl_wdata), 64'(32'h12345678));
            step();
            dec_req = 1'b1; dec_addr = 6'd3;
            t = 0;
            do begin step(); t++; end while (!dec_rvalid && t < 20);
            check_eq({pfx, "raw_data3"}, 64'(dec_rdata), 64'(32'h12345678));

            // Simultaneous requests: decode first, config the cycle after rvalid.
            dec_req = 1'b1; dec_addr = 6'd1; cfg_req = 1'b1; cfg_addr = 6'd2; cfg_wdata = $urandom;
            rv_t = -1; cg_t = -1; dg_t = -1;
            for (int k = 1; k <= 20; k++) begin
                step();
                if (dec_gnt && dg_t < 0) dg_t = k;
                if (dec_rvalid && rv_t < 0) rv_t = k;
                if (cfg_gnt && cg_t < 0) cg_t = k;
            end
            check_eq({pfx, "both_dec_first"}, 64'(dg_t), 64'(1));
            check_eq({pfx, "both_cfg_after_rv"}, 64'(cg_t), 64'(rv_t + 1));

            // Reset one cycle after a decode grant discards the read.
            dec_req = 1'b1; dec_addr = 6'd3;
            t = 0;
            do begin step(); t++; end while (!dec_gnt && t < 20);
            step();
            rst_n = 1'b0;
            #1;
            check_eq({pfx, "reset_outs"},
                     64'({dec_gnt, cfg_gnt, dec_rvalid, tbl_en, tbl_we, busy, tbl_addr}),
                     64'(0));
            check_eq({pfx, "reset_data"}, {tbl_wdata, dec_rdata}, 64'(0));
            model_reset();
            @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (LAT + 3) step();
            dec_req = 1'b1; dec_addr = 6'd5;
            t = 0;
            do begin step(); t++; end while (!dec_rvalid && t < 20);
            check_eq({pfx, "post_reset_lat"}, 64'(t), 64'(LAT + 2));
            check_eq({pfx, "post_reset_data"}, 64'(dec_rdata), 64'(32'hDEADBEEF));

            // Continuous load from both sides: STARVE_MAX decode grants per config grant.
            md = 2; mc = 2; run = 0; seen = 0;
            repeat (100) begin
                step();
                if (dec_gnt) run++;
                if (cfg_gnt) begin
                    if (seen) check_eq({pfx, "starve_run"}, 64'(run), 64'(SMAX));
                    seen = 1; run = 0;
                end
            end

            md = 1; mc = 1;
            repeat (400) step();
            md = 0; mc = 0;
            repeat (20) step();
            done = 1'b1;
        end
    end

    initial begin
        int waited;
        waited = 0;
        while (!(g_lat[0].done && g_lat[1].done && g_lat[2].done) && waited < 20000) begin
            @(posedge clk);
            waited++;
        end
        if (waited >= 20000) check_eq("timeout", 64'(0), 64'(1));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
